// File: rtl/apb_timer_slave.sv
// APB completer with wait-state insertion, wrapping a prescaled down-counting timer
// with auto-reload, sticky EXPIRED status and a registered level interrupt.
module apb_timer_slave #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic        pclk,
  input  logic        Reset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [4:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        irq
);

  localparam int unsigned WAIT_W  = 4;
  localparam int unsigned CMP_W   = 5;
  localparam int unsigned PRESC_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CMP_W-1:0]    wait_inc;
  logic                ready_d;
  logic                pslverr_d;
  logic [31:0]         prdata_d;

  logic                ctrl_en, ctrl_auto, ctrl_irq_en;
  logic [PRESC_W-1:0]  presc_q, presc_cnt_q;
  logic [CNT_W-1:0]    load_q, count_q;
  logic                expired_q;

  logic [2:0]          reg_idx;
  logic                mapped_c;
  logic                access_c, complete_c;
  logic                wr_ctrl, wr_presc, wr_load, wr_stat;
  logic                tick_c, eff_tick_c, at_zero_c, expire_c;
  logic [31:0]         rd_data_c;
  logic                addr_unused;

  assign addr_unused = ^paddr[1:0];

  assign reg_idx    = paddr[4:2];
  assign mapped_c   = (reg_idx <= 3'd4);
  // A data phase only counts when it follows a setup phase.
  assign access_c   = psel & penable & (state_q != IDLE);
  assign complete_c = access_c & pready;

  assign wr_ctrl  = complete_c & pwrite & (reg_idx == 3'd0);
  assign wr_presc = complete_c & pwrite & (reg_idx == 3'd1);
  assign wr_load  = complete_c & pwrite & (reg_idx == 3'd2);
  assign wr_stat  = complete_c & pwrite & (reg_idx == 3'd4);

  assign tick_c     = ctrl_en & (presc_cnt_q == presc_q);
  // Register writes to CTRL or LOAD pre-empt a coincident tick.
  assign eff_tick_c = tick_c & ~wr_ctrl & ~wr_load;
  assign at_zero_c  = (count_q == '0);
  assign expire_c   = eff_tick_c & at_zero_c;

  always_comb begin
    rd_data_c = '0;
    case (reg_idx)
      3'd0:    rd_data_c = 32'({ctrl_irq_en, ctrl_auto, ctrl_en});
      3'd1:    rd_data_c = 32'(presc_q);
      3'd2:    rd_data_c = 32'(load_q);
      3'd3:    rd_data_c = 32'(count_q);
      3'd4:    rd_data_c = 32'(expired_q);
      default: rd_data_c = '0;
    endcase
  end

  // Bus FSM next state and the response for the following cycle.
  always_comb begin
    state_d  = IDLE;
    wait_d   = '0;
    ready_d  = 1'b0;
    wait_inc = CMP_W'(wait_q) + CMP_W'(1);
    if (psel && !penable) begin
      state_d = SETUP;
      ready_d = (WAIT_STATES == 0);
    end else if (access_c && !pready) begin
      state_d = ACCESS;
      wait_d  = WAIT_W'(wait_inc);
      ready_d = (wait_inc >= CMP_W'(WAIT_STATES));
    end
    pslverr_d = ready_d & ~mapped_c;
    prdata_d  = (ready_d && !pwrite) ? rd_data_c : '0;
  end

  always_ff @(posedge pclk) begin
    if (Reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pready  <= ready_d;
      pslverr <= pslverr_d;
      prdata  <= prdata_d;
    end
  end

  always_ff @(posedge pclk) begin
    if (Reset) begin
      ctrl_en     <= 1'b0;
      ctrl_auto   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      presc_q     <= '0;
      load_q      <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en     <= pwdata[0];
        ctrl_auto   <= pwdata[1];
        ctrl_irq_en <= pwdata[2];
      end else if (expire_c && !ctrl_auto) begin
        ctrl_en <= 1'b0;
      end
      if (wr_presc) presc_q <= pwdata[PRESC_W-1:0];
      if (wr_load)  load_q  <= pwdata[CNT_W-1:0];
    end
  end

  // Prescaler, counter, status and interrupt.
  always_ff @(posedge pclk) begin
    if (Reset) begin
      presc_cnt_q <= '0;
      count_q     <= '0;
      expired_q   <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (!ctrl_en || wr_load || tick_c) presc_cnt_q <= '0;
      else                               presc_cnt_q <= presc_cnt_q + PRESC_W'(1);

      if (wr_load) begin
        count_q <= pwdata[CNT_W-1:0];
      end else if (eff_tick_c) begin
        if (!at_zero_c)     count_q <= count_q - CNT_W'(1);
        else if (ctrl_auto) count_q <= load_q;
      end

      expired_q <= expire_c | (expired_q & ~(wr_stat & pwdata[0]));
      irq       <= expired_q & ctrl_irq_en;
    end
  end

endmodule
